// File: rtl/sort_desc_stream_pkg.sv
// Shared types, default sizes and width helper for the descending stream sorter.
package sort_desc_pkg;

  localparam int DEF_N = 6;
  localparam int DEF_W = 32;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  // Width of a counter or tag that indexes n entries; never narrower than 1 bit.
  function automatic int clog2_n(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_desc_stream_if.sv
// Producer/consumer handshake bundle for sort_desc_stream; out_idx exists only with SORT_INDEX_EN.
interface sort_desc_stream_if
  import sort_desc_pkg::*;
#(
  parameter int W = DEF_W
`ifdef SORT_INDEX_EN
  , parameter int N = DEF_N
`endif
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
`ifdef SORT_INDEX_EN
  logic [clog2_n(N)-1:0] out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_idx
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
`endif

endinterface

// File: rtl/sort_desc_stream_cmp_swap.sv
// Combinational compare-exchange: larger word to hi, smaller to lo; ties and en=0 pass through.
// Tags follow their words when SORT_INDEX_EN is defined.
module cmp_swap_desc #(
  parameter int W = 32
`ifdef SORT_INDEX_EN
  , parameter int TW = 3
`endif
) (
  input  logic          en,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
`ifdef SORT_INDEX_EN
  input  logic [TW-1:0] a_tag,
  input  logic [TW-1:0] b_tag,
  output logic [TW-1:0] hi_tag,
  output logic [TW-1:0] lo_tag,
`endif
  output logic [W-1:0]  hi,
  output logic [W-1:0]  lo
);

  // Strict compare keeps equal words in arrival order.
  logic swap;
  assign swap = en && (a < b);

  assign hi = swap ? b : a;
  assign lo = swap ? a : b;

`ifdef SORT_INDEX_EN
  assign hi_tag = swap ? b_tag : a_tag;
  assign lo_tag = swap ? a_tag : b_tag;
`endif

endmodule

// File: rtl/sort_desc_stream.sv
// Loads N words, sorts them descending with N odd-even transposition passes, streams them out
// largest first; no frame overlap. Optional arrival-index tags with SORT_INDEX_EN.
module sort_desc_stream
  import sort_desc_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic             clk,
  input  logic             rst,
  sort_desc_stream_if.slave bus,
  output logic             busy
);

  localparam int CW = clog2_n(N);
  localparam int K  = N / 2;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_n;
  logic [CW-1:0] wr_cnt, pass_cnt, rd_cnt;
  logic [W-1:0]  mem  [N];
  logic [W-1:0]  srt  [N];
  logic [W-1:0]  c_a  [K];
  logic [W-1:0]  c_b  [K];
  logic [W-1:0]  c_hi [K];
  logic [W-1:0]  c_lo [K];
  logic          c_en [K];
  logic          odd_pass, in_fire, out_fire;
`ifdef SORT_INDEX_EN
  logic [CW-1:0] tag    [N];
  logic [CW-1:0] srt_t  [N];
  logic [CW-1:0] c_at   [K];
  logic [CW-1:0] c_bt   [K];
  logic [CW-1:0] c_hit  [K];
  logic [CW-1:0] c_lot  [K];
`endif

  assign odd_pass = pass_cnt[0];
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  // Cell k serves pair (2k,2k+1) on even passes and (2k+1,2k+2) on odd passes.
  for (genvar k = 0; k < K; k++) begin : g_cell
    if (2 * k + 2 < N) begin : g_full
      assign c_a[k]  = odd_pass ? mem[2*k+1] : mem[2*k];
      assign c_b[k]  = odd_pass ? mem[2*k+2] : mem[2*k+1];
      assign c_en[k] = 1'b1;
`ifdef SORT_INDEX_EN
      assign c_at[k] = odd_pass ? tag[2*k+1] : tag[2*k];
      assign c_bt[k] = odd_pass ? tag[2*k+2] : tag[2*k+1];
`endif
    end else begin : g_edge
      assign c_a[k]  = mem[2*k];
      assign c_b[k]  = mem[2*k+1];
      assign c_en[k] = !odd_pass;
`ifdef SORT_INDEX_EN
      assign c_at[k] = tag[2*k];
      assign c_bt[k] = tag[2*k+1];
`endif
    end

    cmp_swap_desc #(
      .W (W)
`ifdef SORT_INDEX_EN
      , .TW(CW)
`endif
    ) u_cs (
      .en     (c_en[k]),
      .a      (c_a[k]),
      .b      (c_b[k]),
`ifdef SORT_INDEX_EN
      .a_tag  (c_at[k]),
      .b_tag  (c_bt[k]),
      .hi_tag (c_hit[k]),
      .lo_tag (c_lot[k]),
`endif
      .hi     (c_hi[k]),
      .lo     (c_lo[k])
    );
  end

  // Map cell outputs back onto array positions for the current pass parity.
  for (genvar i = 0; i < N; i++) begin : g_pos
    logic [W-1:0] ev, od;
`ifdef SORT_INDEX_EN
    logic [CW-1:0] ev_t, od_t;
`endif
    if (i % 2 == 0 && i + 1 < N) begin : g_ev_hi
      assign ev = c_hi[i/2];
`ifdef SORT_INDEX_EN
      assign ev_t = c_hit[i/2];
`endif
    end else if (i % 2 == 1) begin : g_ev_lo
      assign ev = c_lo[i/2];
`ifdef SORT_INDEX_EN
      assign ev_t = c_lot[i/2];
`endif
    end else begin : g_ev_keep
      assign ev = mem[i];
`ifdef SORT_INDEX_EN
      assign ev_t = tag[i];
`endif
    end

    if (i % 2 == 1 && i + 1 < N) begin : g_od_hi
      assign od = c_hi[(i-1)/2];
`ifdef SORT_INDEX_EN
      assign od_t = c_hit[(i-1)/2];
`endif
    end else if (i % 2 == 0 && i >= 2) begin : g_od_lo
      assign od = c_lo[(i-2)/2];
`ifdef SORT_INDEX_EN
      assign od_t = c_lot[(i-2)/2];
`endif
    end else begin : g_od_keep
      assign od = mem[i];
`ifdef SORT_INDEX_EN
      assign od_t = tag[i];
`endif
    end

    assign srt[i] = odd_pass ? od : ev;
`ifdef SORT_INDEX_EN
    assign srt_t[i] = odd_pass ? od_t : ev_t;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    busy          = 1'b1;
`ifdef SORT_INDEX_EN
    bus.out_idx   = '0;
`endif
    case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (in_fire && wr_cnt == LAST) state_n = SORT;
      end
      SORT: begin
        if (pass_cnt == LAST) state_n = DRAIN;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = mem[rd_cnt];
        bus.out_last  = (rd_cnt == LAST);
`ifdef SORT_INDEX_EN
        bus.out_idx   = tag[rd_cnt];
`endif
        if (out_fire && rd_cnt == LAST) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt   <= '0;
      pass_cnt <= '0;
      rd_cnt   <= '0;
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
`ifdef SORT_INDEX_EN
        tag[i] <= '0;
`endif
      end
    end else begin
      case (state)
        LOAD: if (in_fire) begin
          mem[wr_cnt] <= bus.in_data;
`ifdef SORT_INDEX_EN
          tag[wr_cnt] <= wr_cnt;
`endif
          wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
        end
        SORT: begin
          for (int i = 0; i < N; i++) begin
            mem[i] <= srt[i];
`ifdef SORT_INDEX_EN
            tag[i] <= srt_t[i];
`endif
          end
          pass_cnt <= (pass_cnt == LAST) ? '0 : pass_cnt + 1'b1;
        end
        DRAIN: if (out_fire) begin
          rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_desc_stream.sv
// Directed-vector bench for sort_desc_stream (N=6, W=32); checks out_idx when SORT_INDEX_EN is defined.
module tb_sort_desc_stream;
  import sort_desc_pkg::*;

  typedef logic [31:0] frame_t [6];
  typedef int          idx_t   [6];

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   vectors = 0;
  int   miscompares = 0;

  sort_desc_stream_if bus ();

  sort_desc_stream dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1'b1);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_last"},  bus.out_last,  1'b0);
    check({tag, "_busy"},      busy,          1'b0);
    check({tag, "_out_data"},  bus.out_data,  32'h0);
`ifdef SORT_INDEX_EN
    check({tag, "_out_idx"},   bus.out_idx,   3'd0);
`endif
  endtask

  task automatic load_frame(input frame_t v, input bit hold, input logic [31:0] hold_val);
    for (int i = 0; i < 6; i++) begin
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      n = 0;
      while (!bus.in_ready && n < 50) begin
        tick;
        n++;
      end
      if (n == 50) check("load_timeout", 0, 1);
      check("load_busy", busy, 1'b0);
      tick;
    end
    bus.in_valid = hold;
    bus.in_data  = hold ? hold_val : 32'h0;
  endtask

  task automatic wait_valid(input int exp_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      check("sort_busy", busy, 1'b1);
      check("sort_in_ready", bus.in_ready, 1'b0);
      tick;
      n++;
    end
    check("latency", n, exp_lat);
  endtask

  task automatic drain(input frame_t e, input idx_t ei, input logic [3:0] pat);
    int got, cyc;
    bit stalled;
    logic [31:0] hd;
    logic hl;
    got = 0;
    cyc = 0;
    stalled = 0;
    hd = 0;
    hl = 0;
    while (got < 6 && cyc < 100) begin
      bus.out_ready = pat[3 - (cyc % 4)];
      if (stalled) begin
        check("hold_data", bus.out_data, hd);
        check("hold_last", bus.out_last, hl);
      end
      stalled = 0;
      if (bus.out_valid) begin
        check("drain_in_ready", bus.in_ready, 1'b0);
        check("drain_busy", busy, 1'b1);
        if (bus.out_ready) begin
          check("out_data", bus.out_data, e[got]);
          check("out_last", bus.out_last, got == 5);
`ifdef SORT_INDEX_EN
          check("out_idx", bus.out_idx, ei[got]);
`endif
          got++;
        end else begin
          stalled = 1;
          hd = bus.out_data;
          hl = bus.out_last;
        end
      end
      tick;
      cyc++;
    end
    if (got < 6) check("drain_timeout", got, 6);
    check("post_in_ready", bus.in_ready, 1'b1);
    check("post_out_valid", bus.out_valid, 1'b0);
    check("post_busy", busy, 1'b0);
  endtask

  initial begin
    frame_t f, e;
    idx_t   x;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    check_idle("reset");

    // Basic frame, consumer always ready (also ready while out_valid is low).
    bus.out_ready = 1'b1;
    f = '{5, 1, 9, 3, 7, 2};
    e = '{9, 7, 5, 3, 2, 1};
    x = '{2, 4, 0, 3, 5, 1};
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    drain(e, x, 4'b1111);

    // Same frame under 1-0-0-1 back-pressure.
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    drain(e, x, 4'b1001);

    // Ties and unsigned extremes.
    f = '{32'h0, 32'hFFFF_FFFF, 32'h4, 32'h4, 32'h0, 32'hFFFF_FFFF};
    e = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h4, 32'h4, 32'h0, 32'h0};
    x = '{1, 5, 2, 3, 0, 4};
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    drain(e, x, 4'b1111);

    // Producer holds word 8 through SORT and DRAIN; it must land as word 0 of the next frame.
    f = '{10, 20, 30, 40, 50, 60};
    e = '{60, 50, 40, 30, 20, 10};
    x = '{5, 4, 3, 2, 1, 0};
    load_frame(f, 1'b1, 32'd8);
    wait_valid(6);
    drain(e, x, 4'b1111);
    f = '{8, 1, 2, 3, 4, 5};
    e = '{8, 5, 4, 3, 2, 1};
    x = '{0, 5, 4, 3, 2, 1};
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    drain(e, x, 4'b1111);

    // Reset after three loads, then a fresh frame.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 32'(100 + i);
      tick;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_idle("rst_load");
    f = '{6, 5, 4, 3, 2, 1};
    e = '{6, 5, 4, 3, 2, 1};
    x = '{0, 1, 2, 3, 4, 5};
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    drain(e, x, 4'b1111);

    // Reset two beats into DRAIN, then the same fresh frame.
    f = '{9, 8, 7, 6, 5, 4};
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_idle("rst_drain");
    f = '{6, 5, 4, 3, 2, 1};
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    drain(e, x, 4'b1111);

    // Back-to-back frames.
    f = '{1, 2, 3, 4, 5, 6};
    e = '{6, 5, 4, 3, 2, 1};
    x = '{5, 4, 3, 2, 1, 0};
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    drain(e, x, 4'b1111);
    f = '{60, 10, 50, 20, 40, 30};
    e = '{60, 50, 40, 30, 20, 10};
    x = '{0, 2, 4, 5, 3, 1};
    load_frame(f, 1'b0, 32'h0);
    wait_valid(6);
    drain(e, x, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
